// File: rtl/game_pkg.sv
// Shared game-level encodings and the VGA pixel payload used between drawing stages.
package game_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    PLAY      = 3'd1,
    GAME_OVER = 3'd2
  } main_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing plus rgb bundle passed from one drawing stage to the next.
interface vga_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/draw_fields.sv
// Overlays minesweeper field graphics onto the board image with a fixed 2-cycle latency.
// Optional build macro DRAW_FIELDS_MINE_REVEAL_EN shows mines once the game is frozen.
module draw_fields #(
  parameter logic [10:0] BOARD_XPOS = 11'd192,
  parameter logic [10:0] BOARD_YPOS = 11'd112,
  parameter int unsigned FIELD_SIZE = 32,
  parameter int unsigned GRID       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_state,
  vga_if.in          in,
  vga_if.out         out,
  output logic [7:0] field_addr,
  input  logic [3:0] field_data
);

  localparam int unsigned OFF_W      = $clog2(FIELD_SIZE);
  localparam int unsigned BOARD_PIX  = GRID * FIELD_SIZE;
  localparam logic [10:0] BOARD_XEND = BOARD_XPOS + 11'(BOARD_PIX);
  localparam logic [10:0] BOARD_YEND = BOARD_YPOS + 11'(BOARD_PIX);
  localparam logic [OFF_W-1:0] SQ_LO = OFF_W'(FIELD_SIZE / 4);
  localparam logic [OFF_W-1:0] SQ_HI = OFF_W'(3 * FIELD_SIZE / 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             frame_start;
  logic             in_board;
  logic [10:0]      h_rel, v_rel;
  logic [3:0]       col, row;

  game_pkg::vga_t   pipe1;
  logic             in_board1;
  logic [OFF_W-1:0] h_off1, v_off1;

  logic             revealed;
  logic             in_square;
  logic             on_edge;
  logic [11:0]      rgb_nxt;

  function automatic logic [11:0] num_color(input logic [3:0] n);
    case (n)
      4'd1:    return 12'h00F;
      4'd2:    return 12'h080;
      4'd3:    return 12'hF00;
      4'd4:    return 12'h008;
      4'd5:    return 12'h800;
      4'd6:    return 12'h088;
      4'd7:    return 12'h000;
      4'd8:    return 12'h888;
      default: return 12'hBBB;
    endcase
  endfunction

  // Cycle 0: board hit test and field coordinates (shifts only).
  always_comb begin
    frame_start = (in.hcount == 11'd0) && (in.vcount == 11'd0);
    in_board    = (in.hcount >= BOARD_XPOS) && (in.hcount < BOARD_XEND) &&
                  (in.vcount >= BOARD_YPOS) && (in.vcount < BOARD_YEND);
    h_rel       = in.hcount - BOARD_XPOS;
    v_rel       = in.vcount - BOARD_YPOS;
    col         = 4'(h_rel >> OFF_W);
    row         = 4'(v_rel >> OFF_W);
  end

  // Stage 1: RAM address, in-field offsets and delayed timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe1      <= '0;
      in_board1  <= 1'b0;
      h_off1     <= '0;
      v_off1     <= '0;
      field_addr <= 8'h00;
    end else begin
      pipe1.vcount <= in.vcount;
      pipe1.vsync  <= in.vsync;
      pipe1.vblnk  <= in.vblnk;
      pipe1.hcount <= in.hcount;
      pipe1.hsync  <= in.hsync;
      pipe1.hblnk  <= in.hblnk;
      pipe1.rgb    <= in.rgb;
      in_board1    <= in_board;
      h_off1       <= h_rel[OFF_W-1:0];
      v_off1       <= v_rel[OFF_W-1:0];
      if (in_board) begin
        field_addr <= {row, col};
      end
    end
  end

  // State only moves at frame start so a whole frame is drawn in one mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (main_state == game_pkg::PLAY) state_nxt = DRAW;
        end
        DRAW: begin
          if (main_state == game_pkg::GAME_OVER) state_nxt = FROZEN;
        end
        FROZEN: begin
          if (main_state == game_pkg::PLAY) begin
            state_nxt = DRAW;
          end else if (main_state != game_pkg::GAME_OVER) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage 2 colour: covered fields let the bevelled button from upstream show through.
  always_comb begin
    rgb_nxt   = pipe1.rgb;
    revealed  = (field_data <= 4'd8);
    in_square = (h_off1 >= SQ_LO) && (h_off1 < SQ_HI) &&
                (v_off1 >= SQ_LO) && (v_off1 < SQ_HI);
    on_edge   = (h_off1 == '0) || (v_off1 == '0);
    if ((state != IDLE) && in_board1) begin
      if (revealed) begin
        rgb_nxt = 12'hBBB;
        if ((field_data != 4'd0) && in_square) rgb_nxt = num_color(field_data);
        if (on_edge) rgb_nxt = 12'h777;
      end else if (field_data == 4'd10) begin
        if (in_square) rgb_nxt = 12'hF80;
      end
`ifdef DRAW_FIELDS_MINE_REVEAL_EN
      else if ((field_data == 4'd11) && (state == FROZEN)) begin
        rgb_nxt = in_square ? 12'h000 : 12'hF00;
      end
`endif
    end
    if (pipe1.hblnk || pipe1.vblnk) rgb_nxt = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.vcount <= 11'd0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= 12'h000;
    end else begin
      out.vcount <= pipe1.vcount;
      out.vsync  <= pipe1.vsync;
      out.vblnk  <= pipe1.vblnk;
      out.hcount <= pipe1.hcount;
      out.hsync  <= pipe1.hsync;
      out.hblnk  <= pipe1.hblnk;
      out.rgb    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_fields.sv
// Bench for draw_fields: directed scenarios then random pixels against a frame-level model.
module tb_draw_fields;
  import game_pkg::*;

  localparam int BX   = 192;
  localparam int BY   = 112;
  localparam int FS   = 32;
  localparam int GRID = 8;
  localparam int BW   = GRID * FS;
  localparam logic [11:0] NUM_COL [9] = '{12'hBBB, 12'h00F, 12'h080, 12'hF00, 12'h008,
                                          12'h800, 12'h088, 12'h000, 12'h888};

  typedef struct {
    int h; int v; bit hs; bit vs; bit hb; bit vb; int rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] main_state = MENU;
  logic [7:0] field_addr;
  logic [3:0] field_data;
  logic [3:0] ram [256];

  vga_if vin ();
  vga_if vout ();

  int   checks = 0;
  int   failures = 0;
  int   mstate = 0;           // 0 idle, 1 drawing, 2 frozen
  logic [7:0] exp_addr = 8'h00;
  exp_t q[$];

  assign field_data = ram[field_addr];

  draw_fields dut (
    .clk        (clk),
    .rst        (rst),
    .main_state (main_state),
    .in         (vin),
    .out        (vout),
    .field_addr (field_addr),
    .field_data (field_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit on_board(input int h, input int v);
    return (h >= BX) && (h < BX + BW) && (v >= BY) && (v < BY + BW);
  endfunction

  function automatic int next_state(input int s, input logic [2:0] ms);
    if (s == 0) return (ms == PLAY) ? 1 : 0;
    if (s == 1) return (ms == GAME_OVER) ? 2 : 1;
    if (ms == PLAY) return 1;
    return (ms == GAME_OVER) ? 2 : 0;
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] rgb,
                                            input bit blank);
    int code, ho, vo;
    bit sq;
    if (blank) return 12'h000;
    if (mstate == 0 || !on_board(h, v)) return rgb;
    ho   = (h - BX) % FS;
    vo   = (v - BY) % FS;
    code = int'(ram[((v - BY) / FS) * 16 + (h - BX) / FS]);
    sq   = (ho >= FS / 4) && (ho < 3 * FS / 4) && (vo >= FS / 4) && (vo < 3 * FS / 4);
    if (code <= 8) begin
      if (ho == 0 || vo == 0) return 12'h777;
      if (code > 0 && sq) return NUM_COL[code];
      return 12'hBBB;
    end
    if (code == 10) return sq ? 12'hF80 : rgb;
`ifdef DRAW_FIELDS_MINE_REVEAL_EN
    if (code == 11 && mstate == 2) return sq ? 12'h000 : 12'hF00;
`endif
    return rgb;
  endfunction

  // One clock: check what the DUT shows now, then present the next input pixel.
  task automatic step(input int h, input int v, input logic [11:0] rgb, input bit hb,
                      input bit vb, input bit hs, input bit vs, input logic [2:0] ms,
                      input bit r);
    exp_t c, e;
    @(posedge clk);
    #1;
    c = q.pop_front();
    chk("out.hcount", 32'(vout.hcount), 32'(c.h));
    chk("out.vcount", 32'(vout.vcount), 32'(c.v));
    chk("out.hsync",  32'(vout.hsync),  32'(c.hs));
    chk("out.vsync",  32'(vout.vsync),  32'(c.vs));
    chk("out.hblnk",  32'(vout.hblnk),  32'(c.hb));
    chk("out.vblnk",  32'(vout.vblnk),  32'(c.vb));
    chk("out.rgb",    32'(vout.rgb),    32'(c.rgb));
    chk("field_addr", 32'(field_addr),  32'(exp_addr));
    rst        = r;
    main_state = ms;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    e = '{default: 0};
    if (r) begin
      foreach (q[i]) q[i] = '{default: 0};
      mstate   = 0;
      exp_addr = 8'h00;
    end else begin
      if (h == 0 && v == 0) mstate = next_state(mstate, ms);
      e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.rgb = int'(model_rgb(h, v, rgb, hb || vb));
      if (on_board(h, v)) exp_addr = 8'(((v - BY) / FS) * 16 + (h - BX) / FS);
    end
    q.push_back(e);
  endtask

  task automatic px(input int h, input int v, input logic [11:0] rgb, input logic [2:0] ms);
    step(h, v, rgb, 1'b0, 1'b0, 1'b0, 1'b0, ms, 1'b0);
  endtask

  task automatic gap(input logic [2:0] ms);
    px(5, 50, 12'h111, ms);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 4'($urandom_range(0, 15));
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk  = 1'b0;  vin.vblnk  = 1'b0;  vin.rgb   = 12'h000;
    q.push_back('{default: 0});
    q.push_back('{default: 0});

    // Reset held three cycles, then the first pixel at frame origin.
    for (int i = 0; i < 3; i++) step(0, 0, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1, MENU, 1'b1);
    step(0, 0, 12'h123, 1'b0, 1'b0, 1'b1, 1'b1, MENU, 1'b0);
    gap(MENU);
    chk("first_px_not_early", 32'(vout.rgb), 32'h000);
    gap(MENU);
    chk("first_px_rgb", 32'(vout.rgb), 32'h123);
    chk("first_px_hcount", 32'(vout.hcount), 32'd0);

    // PLAY mid-frame stays pass-through until the next frame start.
    px(500, 300, 12'h0F0, PLAY);
    px(BX + 48, BY + 80, 12'hABC, PLAY);
    gap(PLAY);
    gap(PLAY);
    chk("midframe_play_passthru", 32'(vout.rgb), 32'hABC);
    px(0, 0, 12'h000, PLAY);

    // Revealed 3 at row 2, col 1 centre.
    ram[8'h21] = 4'd3;
    px(BX + 48, BY + 80, 12'h5A5, PLAY);
    gap(PLAY);
    chk("addr_21", 32'(field_addr), 32'h21);
    gap(PLAY);
    chk("code3_rgb", 32'(vout.rgb), 32'hF00);

    ram[8'h21] = 4'd9;
    px(BX + 48, BY + 80, 12'h5A5, PLAY);
    gap(PLAY);
    gap(PLAY);
    chk("covered_rgb", 32'(vout.rgb), 32'h5A5);

    ram[8'h21] = 4'd10;
    px(BX + 48, BY + 80, 12'h5A5, PLAY);
    gap(PLAY);
    gap(PLAY);
    chk("flag_rgb", 32'(vout.rgb), 32'hF80);

    // Frozen mine at a field centre.
    px(0, 0, 12'h000, GAME_OVER);
    ram[8'h21] = 4'd11;
    px(BX + 48, BY + 80, 12'h5A5, GAME_OVER);
    gap(GAME_OVER);
    gap(GAME_OVER);
`ifdef DRAW_FIELDS_MINE_REVEAL_EN
    chk("frozen_mine_rgb", 32'(vout.rgb), 32'h000);
`else
    chk("frozen_mine_rgb", 32'(vout.rgb), 32'h5A5);
`endif

    // One pixel past the right board edge.
    px(0, 0, 12'h000, PLAY);
    px(BX + BW - 1, BY + 16, 12'h222, PLAY);
    px(BX + BW, BY + 16, 12'h3C3, PLAY);
    gap(PLAY);
    chk("edge_addr_held", 32'(field_addr), 32'h07);
    gap(PLAY);
    chk("edge_passthru", 32'(vout.rgb), 32'h3C3);

    // Random pixels with occasional frame starts, blanking and state requests.
    for (int n = 0; n < 3000; n++) begin
      int h, v, sel;
      logic [2:0] ms;
      sel = $urandom_range(0, 9);
      ms  = (sel < 4) ? PLAY : (sel < 7) ? GAME_OVER : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) begin
        h = 0; v = 0;
      end else begin
        h = BX - 8 + $urandom_range(0, BW + 16);
        v = BY - 8 + $urandom_range(0, BW + 16);
      end
      step(h, v, 12'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 1'($urandom), ms, 1'b0);
    end

    // Reset mid-frame: outputs zero next edge, restart in IDLE.
    px(0, 0, 12'h000, PLAY);
    px(BX + 40, BY + 40, 12'h999, PLAY);
    step(BX + 40, BY + 40, 12'h999, 1'b0, 1'b0, 1'b1, 1'b1, PLAY, 1'b1);
    px(BX + 40, BY + 40, 12'h246, PLAY);
    chk("rst_mid_rgb", 32'(vout.rgb), 32'h000);
    chk("rst_mid_hcount", 32'(vout.hcount), 32'd0);
    gap(PLAY);
    gap(PLAY);
    chk("after_rst_idle", 32'(vout.rgb), 32'h246);
    gap(PLAY);
    gap(PLAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
